// File: rtl/safe_intc_requester.sv
// Turns single-cycle service events into a held level interrupt toward selected cores,
// released by the intc_ack level. Optional request timeout: define SAFE_INTC_REQ_TIMEOUT_EN.
module safe_intc_requester #(
    parameter int NCORES    = 3,
    parameter int PEND_W    = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [NCORES-1:0]    target_mask_i,
    input  logic                 ack_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic                 ovf_clr_i,
    output logic [NCORES-1:0]    intc_o,
    output logic                 busy_o,
    output logic [PEND_W-1:0]    pend_cnt_o,
    output logic                 overflow_o,
    output logic                 timeout_o
);
    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state_reg;
    logic [NCORES-1:0] mask_reg;
    logic [NCORES-1:0] intc_reg;
    logic              busy_reg;
    logic [PEND_W-1:0] pend_reg;
    logic              ovf_reg;
    logic              launch;
    logic              expire;
    logic              done;

    // A new request may only launch once software has dropped the previous ack.
    assign launch = (state_reg == IDLE) && (pend_reg != '0) && !ack_i;

`ifdef SAFE_INTC_REQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer_reg;
    logic                 tmo_reg;

    // Ack wins over an expiry landing in the same cycle.
    assign expire = (state_reg == ASSERT) && !ack_i && (timer_reg == TIMEOUT_W'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_reg <= '0;
            tmo_reg   <= 1'b0;
        end else begin
            tmo_reg <= expire;
            if (launch)
                timer_reg <= timeout_i;
            else if (state_reg == ASSERT && timer_reg != '0)
                timer_reg <= timer_reg - TIMEOUT_W'(1);
        end
    end

    assign timeout_o = tmo_reg;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_i;
    assign expire         = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    assign done = (state_reg == ASSERT) && (ack_i || expire);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            intc_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        state_reg <= ASSERT;
                        mask_reg  <= target_mask_i;
                        intc_reg  <= target_mask_i;
                        busy_reg  <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (ack_i) begin
                        state_reg <= RELEASE;
                        intc_reg  <= '0;
                    end else if (expire) begin
                        state_reg <= IDLE;
                        intc_reg  <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        intc_reg  <= mask_reg;
                    end
                end
                RELEASE: begin
                    if (!ack_i) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    intc_reg  <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Overflow only flags events actually lost; a same-cycle completion makes room.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            case ({req_i, done})
                2'b10: begin
                    if (pend_reg == PEND_MAX)
                        ovf_reg <= 1'b1;
                    else
                        pend_reg <= pend_reg + PEND_W'(1);
                end
                2'b01:   pend_reg <= pend_reg - PEND_W'(1);
                default: pend_reg <= pend_reg;
            endcase
            if (ovf_clr_i && !(req_i && !done && pend_reg == PEND_MAX))
                ovf_reg <= 1'b0;
        end
    end

    assign intc_o     = intc_reg;
    assign busy_o     = busy_reg;
    assign pend_cnt_o = pend_reg;
    assign overflow_o = ovf_reg;

endmodule

// File: tb/tb_safe_intc_requester.sv
// Directed bench for safe_intc_requester; timeout checks follow SAFE_INTC_REQ_TIMEOUT_EN.
module tb_safe_intc_requester;
    localparam int NCORES    = 3;
    localparam int PEND_W    = 4;
    localparam int TIMEOUT_W = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_i;
    logic [NCORES-1:0]    target_mask_i;
    logic                 ack_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic                 ovf_clr_i;
    logic [NCORES-1:0]    intc_o;
    logic                 busy_o;
    logic [PEND_W-1:0]    pend_cnt_o;
    logic                 overflow_o;
    logic                 timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    safe_intc_requester #(.NCORES(NCORES), .PEND_W(PEND_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .target_mask_i (target_mask_i),
        .ack_i         (ack_i),
        .timeout_i     (timeout_i),
        .ovf_clr_i     (ovf_clr_i),
        .intc_o        (intc_o),
        .busy_o        (busy_o),
        .pend_cnt_o    (pend_cnt_o),
        .overflow_o    (overflow_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".intc"}, 32'(intc_o), 32'd0);
        chk({tag, ".busy"}, 32'(busy_o), 32'd0);
        chk({tag, ".pend"}, 32'(pend_cnt_o), 32'd0);
        chk({tag, ".ovf"},  32'(overflow_o), 32'd0);
        chk({tag, ".tmo"},  32'(timeout_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; target_mask_i = '0; ack_i = 1'b0;
        timeout_i = '0; ovf_clr_i = 1'b0;
        step(); step();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        step();

        // Single request, ack, release
        target_mask_i = 3'b101; req_i = 1'b1;
        step();
        req_i = 1'b0;
        chk("t1.pend1", 32'(pend_cnt_o), 32'd1);
        chk("t1.intc_lat", 32'(intc_o), 32'd0);
        step();
        chk("t1.intc_on", 32'(intc_o), 32'h5);
        chk("t1.busy", 32'(busy_o), 32'd1);
        target_mask_i = 3'b010;
        for (int i = 0; i < 7; i++) step();
        chk("t1.intc_hold", 32'(intc_o), 32'h5);
        ack_i = 1'b1;
        step();
        chk("t1.intc_off", 32'(intc_o), 32'd0);
        chk("t1.pend0", 32'(pend_cnt_o), 32'd0);
        chk("t1.busy_rel", 32'(busy_o), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("t1.still_rel", 32'(busy_o), 32'd1);
        ack_i = 1'b0;
        step();
        chk("t1.idle", 32'(busy_o), 32'd0);
        step();
        chk("t1.no_relaunch", 32'(intc_o), 32'd0);

        // Queued events while asserted, serviced one by one
        target_mask_i = 3'b011; req_i = 1'b1;
        step();
        req_i = 1'b0;
        step();
        chk("t2.intc_on", 32'(intc_o), 32'h3);
        target_mask_i = 3'b100;
        req_i = 1'b1;
        step(); step(); step();
        req_i = 1'b0;
        chk("t2.pend4", 32'(pend_cnt_o), 32'd4);
        chk("t2.mask_latched", 32'(intc_o), 32'h3);
        for (int k = 0; k < 4; k++) begin
            ack_i = 1'b1;
            step();
            chk("t2.ack_intc", 32'(intc_o), 32'd0);
            chk("t2.ack_pend", 32'(pend_cnt_o), 32'(3 - k));
            ack_i = 1'b0;
            step();
            chk("t2.rel_idle", 32'(busy_o), 32'd0);
            step();
            if (k < 3) begin
                chk("t2.relaunch", 32'(intc_o), 32'h4);
                chk("t2.relaunch_bsy", 32'(busy_o), 32'd1);
            end else begin
                chk("t2.drained_intc", 32'(intc_o), 32'd0);
                chk("t2.drained_bsy", 32'(busy_o), 32'd0);
            end
        end

        // Zero mask still runs the handshake
        target_mask_i = 3'b000; req_i = 1'b1;
        step();
        req_i = 1'b0;
        step();
        chk("t3.zero_busy", 32'(busy_o), 32'd1);
        chk("t3.zero_intc", 32'(intc_o), 32'd0);
        ack_i = 1'b1;
        step();
        chk("t3.zero_pend", 32'(pend_cnt_o), 32'd0);
        ack_i = 1'b0;
        step();
        chk("t3.zero_idle", 32'(busy_o), 32'd0);

`ifdef SAFE_INTC_REQ_TIMEOUT_EN
        // Timeout of 5 cycles; mid-request change ignored
        timeout_i = 16'd5; target_mask_i = 3'b111; req_i = 1'b1;
        step();
        req_i = 1'b0;
        step();
        chk("t4.intc_on", 32'(intc_o), 32'h7);
        timeout_i = 16'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4.intc_held", 32'(intc_o), 32'h7);
            chk("t4.tmo_low", 32'(timeout_o), 32'd0);
        end
        step();
        chk("t4.intc_off", 32'(intc_o), 32'd0);
        chk("t4.tmo_pulse", 32'(timeout_o), 32'd1);
        chk("t4.pend0", 32'(pend_cnt_o), 32'd0);
        chk("t4.idle", 32'(busy_o), 32'd0);
        step();
        chk("t4.tmo_once", 32'(timeout_o), 32'd0);

        // Ack coincides with expiry
        timeout_i = 16'd3; req_i = 1'b1;
        step();
        req_i = 1'b0;
        step(); step(); step();
        chk("t5.intc_on", 32'(intc_o), 32'h7);
        ack_i = 1'b1;
        step();
        chk("t5.intc_off", 32'(intc_o), 32'd0);
        chk("t5.tmo_low", 32'(timeout_o), 32'd0);
        chk("t5.release", 32'(busy_o), 32'd1);
        chk("t5.pend0", 32'(pend_cnt_o), 32'd0);
        ack_i = 1'b0;
        step();
        chk("t5.idle", 32'(busy_o), 32'd0);
        timeout_i = '0;
`else
        // Without the timer, a set timeout never releases the request
        timeout_i = 16'd3; target_mask_i = 3'b111; req_i = 1'b1;
        step();
        req_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t4.no_tmo_intc", 32'(intc_o), 32'h7);
        chk("t4.no_tmo_pulse", 32'(timeout_o), 32'd0);
        chk("t4.no_tmo_pend", 32'(pend_cnt_o), 32'd1);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        chk("t4.idle", 32'(busy_o), 32'd0);
        timeout_i = '0;
`endif

        // Saturation and overflow
        target_mask_i = 3'b010; req_i = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("t6.pend15", 32'(pend_cnt_o), 32'd15);
        chk("t6.ovf_clear", 32'(overflow_o), 32'd0);
        step(); step();
        req_i = 1'b0;
        chk("t6.pend_sat", 32'(pend_cnt_o), 32'd15);
        chk("t6.ovf_set", 32'(overflow_o), 32'd1);
        req_i = 1'b1; ovf_clr_i = 1'b1;
        step();
        req_i = 1'b0;
        chk("t6.set_wins", 32'(overflow_o), 32'd1);
        step();
        ovf_clr_i = 1'b0;
        chk("t6.ovf_clr", 32'(overflow_o), 32'd0);
        chk("t6.pend_kept", 32'(pend_cnt_o), 32'd15);
        rst_ni = 1'b0;
        step();
        chk_all_zero("t6.rst");
        rst_ni = 1'b1;
        step();

        // Reset during ASSERT with three pending
        target_mask_i = 3'b110; req_i = 1'b1;
        step(); step(); step();
        req_i = 1'b0;
        chk("t7.pend3", 32'(pend_cnt_o), 32'd3);
        chk("t7.intc_on", 32'(intc_o), 32'h6);
        rst_ni = 1'b0;
        step();
        chk_all_zero("t7.rst");
        rst_ni = 1'b1;
        step();
        chk("t7.stay_idle", 32'(intc_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
